mcoi_ps_buffer_mux: RTL

//  Multi-channel writer into the PS shared-memory BRAM port. Up to NCH PL producers
//  (motor diagnostics, GBT frame snapshots, etc.) push words via valid/ready.
//  A round-robin arbiter serialises them into per-channel regions of the BRAM.

---
 rtl/mcoi_ps_buffer_mux_pkg.sv | 27 ++
 rtl/mcoi_ps_buffer_mux_if.sv | 32 +++
 rtl/mcoi_ps_buffer_mux_rr_arbiter.sv | 42 ++++
 rtl/mcoi_ps_buffer_mux.sv | 122 ++++++++++++
 4 files changed

// File: rtl/mcoi_ps_buffer_mux_pkg.sv
// Shared types, constants and address helper for the PS shared-memory buffer mux.
package mcoi_ps_buffer_mux_pkg;

   // Default words per channel region.
   localparam int PSBUF_DEPTH_DEFAULT = 256;

   // Write pointer for a region of the default depth.
   typedef logic [$clog2(PSBUF_DEPTH_DEFAULT)-1:0] ps_buf_wptr_t;

   // Region behaviour once the last index has been written.
   typedef enum logic {
      PSBUF_RING    = 1'b0,
      PSBUF_ONESHOT = 1'b1
   } ps_buf_mode_t;

   // Byte address of word idx inside the region of channel ch.
   function automatic logic [63:0] psbuf_region_addr(
      input logic [63:0] base,
      input int unsigned ch,
      input int unsigned idx,
      input int unsigned depth,
      input int unsigned bytes_per_word
   );
      return base + (64'(ch) * 64'(depth) + 64'(idx)) * 64'(bytes_per_word);
   endfunction

endpackage

// File: rtl/mcoi_ps_buffer_mux_if.sv
// Producer handshake, BRAM write port and status bundle of the buffer mux.
interface mcoi_ps_buffer_mux_if #(
   parameter int NCH = 4,
   parameter int DW  = 32,
   parameter int AW  = 32,
   parameter int PW  = 8
);
   logic [NCH-1:0][DW-1:0] ch_data;
   logic [NCH-1:0]         ch_valid;
   logic [NCH-1:0]         ch_ready;
   logic [NCH-1:0]         ch_enable;
   logic [NCH-1:0]         ch_clear;
   logic                   mem_en;
   logic [DW/8-1:0]        mem_we;
   logic [AW-1:0]          mem_addr;
   logic [DW-1:0]          mem_din;
   logic [NCH-1:0][PW-1:0] wptr;
   logic [NCH-1:0]         wrap;
   logic [NCH-1:0]         full;

   // The buffer mux itself.
   modport slave (
      input  ch_data, ch_valid, ch_enable, ch_clear,
      output ch_ready, mem_en, mem_we, mem_addr, mem_din, wptr, wrap, full
   );

   // Application / PS side.
   modport master (
      output ch_data, ch_valid, ch_enable, ch_clear,
      input  ch_ready, mem_en, mem_we, mem_addr, mem_din, wptr, wrap, full
   );
endinterface

// File: rtl/mcoi_ps_buffer_mux_rr_arbiter.sv
// Round-robin arbiter: one-hot combinational grant, search starts one past the
// last served requester; the start pointer only moves when advance is high.
module mcoi_ps_buffer_mux_rr_arbiter #(
   parameter  int N  = 4,
   localparam int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  req,
   input  logic          advance,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          any
);
   logic [IW-1:0] start_reg;

   // First requester found scanning circularly from start_reg.
   always_comb begin
      int idx;
      grant     = '0;
      grant_idx = '0;
      any       = 1'b0;
      idx       = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(start_reg) + k) % N;
         if (!any && req[idx]) begin
            grant[idx] = 1'b1;
            grant_idx  = IW'(idx);
            any        = 1'b1;
         end
      end
   end

   // Next search start = granted channel + 1, wrapping at N.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         start_reg <= '0;
      end else if (advance && any) begin
         start_reg <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
      end
   end
endmodule

// File: rtl/mcoi_ps_buffer_mux.sv
// Multi-channel writer into the PS shared-memory BRAM port. Producers are
// serialised round-robin into per-channel ring or one-shot regions.
module mcoi_ps_buffer_mux
   import mcoi_ps_buffer_mux_pkg::*;
#(
   parameter int              NCH       = 4,
   parameter int              DW        = 32,
   parameter int              AW        = 32,
   parameter int              DEPTH     = PSBUF_DEPTH_DEFAULT,
   parameter longint unsigned BASE_ADDR = 0,
   parameter logic [NCH-1:0]  ONESHOT   = '0
) (
   input  logic               clk,
   input  logic               rst,
   mcoi_ps_buffer_mux_if.slave bus
);
   localparam int PW  = $clog2(DEPTH);
   localparam int BPW = DW / 8;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;

   localparam logic [64:0] ADDR_LIMIT = 65'(1) << AW;
   localparam logic [64:0] ADDR_END   = 65'(BASE_ADDR) + 65'(NCH) * 65'(DEPTH) * 65'(BPW);

   // Reject configurations the address arithmetic or pointer logic cannot honour.
   if (NCH < 1 || NCH > 16) begin : g_bad_nch
      $error("NCH must be in 1..16");
   end
   if (DW < 8 || (DW % 8) != 0) begin : g_bad_dw
      $error("DW must be a multiple of 8");
   end
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("DEPTH must be a power of 2 and at least 2");
   end
   if (ADDR_END > ADDR_LIMIT) begin : g_bad_aw
      $error("Buffer regions do not fit in AW address bits");
   end

   logic [NCH-1:0]         eligible;
   logic [NCH-1:0]         grant;
   logic [IW-1:0]          grant_idx;
   logic                   any_grant;
   logic [NCH-1:0][PW-1:0] wptr_vec;
   logic [NCH-1:0]         wrap_vec;
   logic [NCH-1:0]         full_vec;
   logic [AW-1:0]          mem_addr_next;
   logic                   mem_en_reg;
   logic [AW-1:0]          mem_addr_reg;
   logic [DW-1:0]          mem_din_reg;

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      localparam ps_buf_mode_t MODE = ps_buf_mode_t'(ONESHOT[gi]);

      logic [PW-1:0] wptr_reg;
      logic          wrap_reg;
      logic          full_reg;

      // Clear and a full one-shot region both block the request; reset holds all off.
      assign eligible[gi] = bus.ch_valid[gi] & bus.ch_enable[gi] & ~full_reg
                          & ~bus.ch_clear[gi] & ~rst;

      // Write index and sticky flags; clear wins over everything else.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            wptr_reg <= '0;
            wrap_reg <= 1'b0;
            full_reg <= 1'b0;
         end else if (bus.ch_clear[gi]) begin
            wptr_reg <= '0;
            wrap_reg <= 1'b0;
            full_reg <= 1'b0;
         end else if (grant[gi]) begin
            wptr_reg <= wptr_reg + 1'b1;
            if (wptr_reg == PW'(DEPTH - 1)) begin
               if (MODE == PSBUF_ONESHOT) full_reg <= 1'b1;
               else                       wrap_reg <= 1'b1;
            end
         end
      end

      assign wptr_vec[gi] = wptr_reg;
      assign wrap_vec[gi] = wrap_reg;
      assign full_vec[gi] = full_reg;
   end

   mcoi_ps_buffer_mux_rr_arbiter #(.N(NCH)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .req       (eligible),
      .advance   (any_grant),
      .grant     (grant),
      .grant_idx (grant_idx),
      .any       (any_grant)
   );

   assign mem_addr_next = AW'(psbuf_region_addr(64'(BASE_ADDR), 32'(grant_idx),
                                                32'(wptr_vec[grant_idx]), DEPTH, BPW));

   // BRAM write register: one-cycle latency after the handshake; address and
   // data hold on idle cycles so only the enables toggle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_en_reg   <= 1'b0;
         mem_addr_reg <= '0;
         mem_din_reg  <= '0;
      end else begin
         mem_en_reg <= any_grant;
         if (any_grant) begin
            mem_addr_reg <= mem_addr_next;
            mem_din_reg  <= bus.ch_data[grant_idx];
         end
      end
   end

   assign bus.ch_ready = grant;
   assign bus.mem_en   = mem_en_reg;
   assign bus.mem_we   = {BPW{mem_en_reg}};
   assign bus.mem_addr = mem_addr_reg;
   assign bus.mem_din  = mem_din_reg;
   assign bus.wptr     = wptr_vec;
   assign bus.wrap     = wrap_vec;
   assign bus.full     = full_vec;
endmodule
